// File: rtl/pwm_ctrl_scheduler_pkg.sv
// Shared types and constants for the PWM controller/scheduler slice.
package pwm_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 3;

  // Write address that selects the period-top register.
  localparam logic [ADDR_W-1:0] ADDR_TOP = 3'd7;

  // Register values after reset.
  localparam logic [CNT_W-1:0] TOP_RST  = 4'd15;
  localparam logic [CNT_W-1:0] DUTY_RST = 4'd0;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    DRAIN
  } state_t;

  // Identifies which requester holds round-robin priority.
  typedef enum logic {
    REQ_A,
    REQ_B
  } req_t;

endpackage

// File: rtl/pwm_ctrl_scheduler_if.sv
// Configuration write port shared by the two requesters (A and B).
interface pwm_ctrl_scheduler_if;
  import pwm_pkg::*;

  logic              VALID_A;
  logic [ADDR_W-1:0] ADDR_A;
  logic [CNT_W-1:0]  DATA_A;
  logic              READY_A;

  logic              VALID_B;
  logic [ADDR_W-1:0] ADDR_B;
  logic [CNT_W-1:0]  DATA_B;
  logic              READY_B;

  // Requester side: both front-ends driven from one place.
  modport master (
    output VALID_A, ADDR_A, DATA_A,
    output VALID_B, ADDR_B, DATA_B,
    input  READY_A, READY_B
  );

  // Controller side.
  modport slave (
    input  VALID_A, ADDR_A, DATA_A,
    input  VALID_B, ADDR_B, DATA_B,
    output READY_A, READY_B
  );

endinterface

// File: rtl/pwm_ctrl_scheduler_arb.sv
// Two-requester round-robin arbiter; priority moves only on a completed transfer.
module pwm_rr_arbiter
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic valid_a,
  input  logic valid_b,
  output logic gnt_a,
  output logic gnt_b
);

  req_t prio_q;

  // Grants are combinational; a grant is only ever given to a valid requester,
  // so a grant always completes a transfer on the next edge.
  always_comb begin
    gnt_a = valid_a && (!valid_b || (prio_q == REQ_A));
    gnt_b = valid_b && (!valid_a || (prio_q == REQ_B));
  end

  // Priority passes to the requester that was not just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= REQ_A;
    end else if (gnt_a) begin
      prio_q <= REQ_B;
    end else if (gnt_b) begin
      prio_q <= REQ_A;
    end
  end

endmodule

// File: rtl/pwm_ctrl_scheduler.sv
// PWM controller: shadow/active duty and top registers, run/stop FSM,
// counter reset generation and per-channel compare outputs.
module pwm_ctrl_scheduler
  import pwm_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic                 CLoK,
  input  logic                 Reset,
  input  logic                 EN,
  input  logic [CNT_W-1:0]     CNTR,
  output logic                 CNT_RST,
  pwm_ctrl_scheduler_if.slave  cfg,
  output logic [NCH-1:0]       PWM,
  output logic                 BOUNDARY
);

  state_t state_q, state_d;

  logic [CNT_W-1:0] sh_duty  [NCH];
  logic [CNT_W-1:0] act_duty [NCH];
  logic [CNT_W-1:0] sh_top;
  logic [CNT_W-1:0] act_top;

  logic              gnt_a, gnt_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_data;

  logic at_top;
  logic running;
  logic copy_en;

  pwm_rr_arbiter u_arb (
    .clk     (CLoK),
    .rst     (Reset),
    .valid_a (cfg.VALID_A),
    .valid_b (cfg.VALID_B),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  assign cfg.READY_A = gnt_a;
  assign cfg.READY_B = gnt_b;

  // Select the granted requester's write onto the single register port.
  always_comb begin
    wr_en   = gnt_a || gnt_b;
    wr_addr = gnt_a ? cfg.ADDR_A : cfg.ADDR_B;
    wr_data = gnt_a ? cfg.DATA_A : cfg.DATA_B;
  end

  // Shadow registers: requester writes land here in any state.
  always_ff @(posedge CLoK or posedge Reset) begin
    if (Reset) begin
      sh_top <= TOP_RST;
      for (int unsigned i = 0; i < NCH; i++) begin
        sh_duty[i] <= DUTY_RST;
      end
    end else if (wr_en) begin
      if (wr_addr == ADDR_TOP) begin
        sh_top <= wr_data;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          sh_duty[i] <= wr_data;
        end
      end
    end
  end

  // Active registers: loaded from shadow only at start or at a period boundary,
  // so a write on the same edge is seen one period later.
  always_ff @(posedge CLoK or posedge Reset) begin
    if (Reset) begin
      act_top <= TOP_RST;
      for (int unsigned i = 0; i < NCH; i++) begin
        act_duty[i] <= DUTY_RST;
      end
    end else if (copy_en) begin
      act_top  <= sh_top;
      act_duty <= sh_duty;
    end
  end

  // Run/stop state register.
  always_ff @(posedge CLoK or posedge Reset) begin
    if (Reset) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  assign at_top = (CNTR == act_top);

  // Next state, counter reset, boundary flag and register-copy strobe.
  // RUN and DRAIN share one branch: DRAIN is simply "running with EN low",
  // so EN returning high resumes RUN without disturbing the current period.
  always_comb begin
    state_d  = state_q;
    copy_en  = 1'b0;
    CNT_RST  = 1'b1;
    BOUNDARY = 1'b0;
    running  = 1'b0;
    unique case (state_q)
      STOP: begin
        if (EN) begin
          state_d = RUN;
          copy_en = 1'b1;
        end
      end
      RUN, DRAIN: begin
        running  = 1'b1;
        CNT_RST  = at_top;
        BOUNDARY = at_top;
        if (EN) begin
          state_d = RUN;
          copy_en = at_top;
        end else if (at_top) begin
          state_d = STOP;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = STOP;
      end
    endcase
  end

  // Per-channel compare against the live counter value.
  always_comb begin
    PWM = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      PWM[i] = running && (CNTR < act_duty[i]);
    end
  end

endmodule

// File: tb/tb_pwm_ctrl_scheduler.sv
// Bench for pwm_ctrl_scheduler: external 4-bit counter, directed scenarios,
// arbitration table and randomized traffic against a behavioural model.
module tb_pwm_ctrl_scheduler;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [3:0] cntr = 4'd0;
  logic cnt_rst;
  logic [NCH-1:0] pwm;
  logic boundary;

  logic va = 1'b0, vb = 1'b0;
  logic [2:0] aa = 3'd0, ab = 3'd0;
  logic [3:0] da = 4'd0, db = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_ctrl_scheduler_if cfg_if ();

  assign cfg_if.VALID_A = va;
  assign cfg_if.ADDR_A  = aa;
  assign cfg_if.DATA_A  = da;
  assign cfg_if.VALID_B = vb;
  assign cfg_if.ADDR_B  = ab;
  assign cfg_if.DATA_B  = db;

  pwm_ctrl_scheduler #(.NCH(NCH)) dut (
    .CLoK     (clk),
    .Reset    (rst),
    .EN       (en),
    .CNTR     (cntr),
    .CNT_RST  (cnt_rst),
    .cfg      (cfg_if.slave),
    .PWM      (pwm),
    .BOUNDARY (boundary)
  );

  always #5 clk = ~clk;

  // The external counter block: no reset of its own, cleared by CNT_RST.
  always @(posedge clk) cntr <= cnt_rst ? 4'd0 : cntr + 4'd1;

  // ---------------- behavioural reference model ----------------
  // The controller is either idle or alive; while alive, each period ends when
  // the count reaches the active top, and EN at that moment decides whether
  // the next period starts (with fresh values) or the controller goes idle.
  logic       m_alive = 1'b0;
  logic [3:0] m_cnt   = 4'd0;
  logic [3:0] m_sduty [NCH];
  logic [3:0] m_aduty [NCH];
  logic [3:0] m_stop  = 4'd15;
  logic [3:0] m_atop  = 4'd15;
  logic       m_prio_b = 1'b0;
  logic [2:0] m_wa;
  logic [3:0] m_wd;

  wire m_cnt_rst = !m_alive || (m_cnt == m_atop);
  wire m_ra = va && (!vb || !m_prio_b);
  wire m_rb = vb && (!va || m_prio_b);

  initial begin
    for (int n = 0; n < NCH; n++) begin
      m_sduty[n] = 4'd0;
      m_aduty[n] = 4'd0;
    end
  end

  always @(posedge clk) m_cnt <= m_cnt_rst ? 4'd0 : m_cnt + 4'd1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_alive  <= 1'b0;
      m_stop   <= 4'd15;
      m_atop   <= 4'd15;
      m_prio_b <= 1'b0;
      for (int n = 0; n < NCH; n++) begin
        m_sduty[n] <= 4'd0;
        m_aduty[n] <= 4'd0;
      end
    end else begin
      if (m_ra || m_rb) begin
        m_wa = m_ra ? aa : ab;
        m_wd = m_ra ? da : db;
        if (m_wa == 3'd7) m_stop <= m_wd;
        else if (int'(m_wa) < NCH) m_sduty[int'(m_wa)] <= m_wd;
        m_prio_b <= m_ra;
      end
      if (!m_alive) begin
        if (en) begin
          m_alive <= 1'b1;
          m_aduty <= m_sduty;
          m_atop  <= m_stop;
        end
      end else if (m_cnt == m_atop) begin
        if (en) begin
          m_aduty <= m_sduty;
          m_atop  <= m_stop;
        end else begin
          m_alive <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [NCH-1:0] e_pwm;
    e_pwm = '0;
    for (int n = 0; n < NCH; n++) e_pwm[n] = m_alive && (m_cnt < m_aduty[n]);
    chk("model_cntr", 32'(cntr), 32'(m_cnt));
    chk("model_cnt_rst", 32'(cnt_rst), 32'(m_cnt_rst));
    chk("model_boundary", 32'(boundary), 32'(m_alive && (m_cnt == m_atop)));
    chk("model_pwm", 32'(pwm), 32'(e_pwm));
    chk("model_ready_a", 32'(cfg_if.READY_A), 32'(m_ra));
    chk("model_ready_b", 32'(cfg_if.READY_B), 32'(m_rb));
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
  endtask

  task automatic write_a(input logic [2:0] a, input logic [3:0] d);
    va = 1'b1; aa = a; da = d;
    step();
    va = 1'b0;
  endtask

  task automatic wait_cntr(input logic [3:0] v);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (cntr == v) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("wait_cntr", 32'(found), 32'd1);
  endtask

  // Number of high cycles of PWM[0] over one 10-cycle period starting at count 0.
  task automatic count_period(output int highs);
    wait_cntr(4'd0);
    highs = 0;
    for (int k = 0; k < 10; k++) begin
      highs += int'(pwm[0]);
      if (k < 9) step();
    end
  endtask

  typedef struct packed {
    logic va;
    logic vb;
    logic ra;
    logic rb;
  } arb_vec_t;

  arb_vec_t arb_tab [11];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    logic took_a, took_b;

    // Priority starts at B here because the preceding directed writes all come from A.
    arb_tab[0]  = '{va: 1'b0, vb: 1'b1, ra: 1'b0, rb: 1'b1};
    arb_tab[1]  = '{va: 1'b1, vb: 1'b1, ra: 1'b1, rb: 1'b0};
    arb_tab[2]  = '{va: 1'b1, vb: 1'b1, ra: 1'b0, rb: 1'b1};
    arb_tab[3]  = '{va: 1'b1, vb: 1'b1, ra: 1'b1, rb: 1'b0};
    arb_tab[4]  = '{va: 1'b1, vb: 1'b1, ra: 1'b0, rb: 1'b1};
    arb_tab[5]  = '{va: 1'b1, vb: 1'b0, ra: 1'b1, rb: 1'b0};
    arb_tab[6]  = '{va: 1'b0, vb: 1'b1, ra: 1'b0, rb: 1'b1};
    arb_tab[7]  = '{va: 1'b0, vb: 1'b0, ra: 1'b0, rb: 1'b0};
    arb_tab[8]  = '{va: 1'b1, vb: 1'b1, ra: 1'b1, rb: 1'b0};
    arb_tab[9]  = '{va: 1'b0, vb: 1'b1, ra: 1'b0, rb: 1'b1};
    arb_tab[10] = '{va: 1'b0, vb: 1'b0, ra: 1'b0, rb: 1'b0};

    // Reset, then idle with EN low.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_cnt_rst", 32'(cnt_rst), 32'd1);
      chk("idle_pwm", 32'(pwm), 32'd0);
      chk("idle_ready", 32'({cfg_if.READY_A, cfg_if.READY_B}), 32'd0);
    end

    // Configure top 9, duty0 3 while stopped, then run two periods.
    va = 1'b1; aa = 3'd7; da = 4'd9;
    #1 chk("lone_a_ready", 32'(cfg_if.READY_A), 32'd1);
    step();
    va = 1'b0;
    write_a(3'd0, 4'd3);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("run_cntr", 32'(cntr), 32'(i % 10));
      chk("run_pwm0", 32'(pwm[0]), 32'((i % 10) < 3));
      chk("run_boundary", 32'(boundary), 32'((i % 10) == 9));
      chk("run_cnt_rst", 32'(cnt_rst), 32'((i % 10) == 9));
    end

    // Mid-period duty change waits for the boundary.
    wait_cntr(4'd4);
    write_a(3'd0, 4'd7);
    chk("midwr_cntr", 32'(cntr), 32'd5);
    chk("midwr_pwm0", 32'(pwm[0]), 32'd0);
    count_period(highs);
    chk("midwr_next_period_highs", 32'(highs), 32'd7);
    // Write transferred on the boundary edge: applies one period later.
    write_a(3'd0, 4'd1);
    count_period(highs);
    chk("bndwr_same_edge_highs", 32'(highs), 32'd7);
    count_period(highs);
    chk("bndwr_later_highs", 32'(highs), 32'd1);

    // Arbitration table (address 5 is discarded with four channels).
    aa = 3'd5; ab = 3'd5;
    for (int r = 0; r < 11; r++) begin
      va = arb_tab[r].va;
      vb = arb_tab[r].vb;
      #1;
      chk("arb_ready_a", 32'(cfg_if.READY_A), 32'(arb_tab[r].ra));
      chk("arb_ready_b", 32'(cfg_if.READY_B), 32'(arb_tab[r].rb));
      step();
    end
    va = 1'b0; vb = 1'b0;

    // EN dropped mid-period: finish the period, then stop.
    wait_cntr(4'd4);
    en = 1'b0;
    wait_cntr(4'd9);
    chk("drain_boundary", 32'(boundary), 32'd1);
    step();
    chk("drain_stop_cnt_rst", 32'(cnt_rst), 32'd1);
    chk("drain_stop_pwm", 32'(pwm), 32'd0);
    chk("drain_stop_boundary", 32'(boundary), 32'd0);
    step();
    chk("stop_cntr", 32'(cntr), 32'd0);
    en = 1'b1;
    step();
    chk("restart_cntr", 32'(cntr), 32'd0);
    chk("restart_pwm0", 32'(pwm[0]), 32'd1);

    // EN dropped then re-raised within the period: counting continues.
    wait_cntr(4'd4);
    en = 1'b0;
    step();
    step();
    chk("reraise_cntr", 32'(cntr), 32'd6);
    en = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("reraise_cont_cntr", 32'(cntr), 32'((7 + j) % 10));
    end

    // Duty 0 stays low, duty above top stays high.
    write_a(3'd0, 4'd0);
    write_a(3'd1, 4'd12);
    wait_cntr(4'd9);
    step();
    for (int k = 0; k < 10; k++) begin
      chk("duty0_low", 32'(pwm[0]), 32'd0);
      chk("duty12_high", 32'(pwm[1]), 32'd1);
      step();
    end

    // Top 0: counter held in reset, duty 1 constantly high.
    write_a(3'd7, 4'd0);
    write_a(3'd0, 4'd1);
    wait_cntr(4'd9);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("top0_cnt_rst", 32'(cnt_rst), 32'd1);
      chk("top0_pwm0", 32'(pwm[0]), 32'd1);
      chk("top0_cntr", 32'(cntr), 32'd0);
      step();
    end

    // Asynchronous reset in the middle of a period.
    write_a(3'd7, 4'd9);
    wait_cntr(4'd5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt_rst", 32'(cnt_rst), 32'd1);
    chk("async_rst_pwm", 32'(pwm), 32'd0);
    chk("async_rst_boundary", 32'(boundary), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("after_rst_pwm", 32'(pwm), 32'd0);

    // Randomized traffic; a pending request is held until granted.
    took_a = 1'b0;
    took_b = 1'b0;
    for (int c = 0; c < 800; c++) begin
      step();
      if (c == 400) rst = 1'b1;
      if (c == 402) rst = 1'b0;
      if (!va || took_a) begin
        va = ($urandom_range(0, 2) == 0);
        aa = 3'($urandom_range(0, 7));
        da = 4'($urandom_range(0, 15));
      end
      if (!vb || took_b) begin
        vb = ($urandom_range(0, 2) == 0);
        ab = 3'($urandom_range(0, 7));
        db = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 24) == 0) en = ~en;
      #1;
      took_a = m_ra;
      took_b = m_rb;
    end
    va = 1'b0;
    vb = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ctrl_scheduler.md
# pwm_ctrl_scheduler

Controller for the PWM generator's shared 4-bit counter and its duty-cycle registers. Drives the counter's synchronous reset to set the period, holds per-channel duty values in shadow/active register pairs, and compares the counter value against them to produce NCH PWM outputs. Two configuration requesters (e.g. button front-end and serial front-end) share the single register write port through a round-robin arbiter. New values take effect only at a period boundary, so no glitched pulses occur.

## Interface
- NCH, 4: number of PWM channels, legal 1..7.
- CLoK  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- EN  in  1  run request; level-sensitive.
- CNTR  in  4  current value from the counter block.
- CNT_RST  out  1  drives counter's Reset input; counter clears on next CLoK edge while high.
- VALID_A, VALID_B  in  1  write request from requester A/B.
- ADDR_A, ADDR_B  in  3  target: 0..NCH-1 = duty of channel n; 7 = period top; others are accepted and discarded.
- DATA_A, DATA_B  in  4  value to write.
- READY_A, READY_B  out  1  grant; transfer occurs on an edge where VALID_x & READY_x.
- PWM  out  NCH  PWM outputs, bit n = channel n.
- BOUNDARY  out  1  high in the last cycle of each period (CNTR == active top) while running.

## Operation
- Registers: shadow duty[NCH], shadow top; active duty[NCH], active top. Requester writes go to shadow only.
- FSM states: STOP, RUN, DRAIN.
  - STOP: CNT_RST = 1, PWM = 0, BOUNDARY = 0. EN = 1 -> RUN, copying all shadow to active on that edge.
  - RUN: CNT_RST = (CNTR == active top). At that boundary edge shadow copies to active. EN = 0 -> DRAIN; if that cycle is also a boundary, go directly to STOP.
  - DRAIN: as RUN, but at the boundary edge -> STOP, with no copy. EN returning to 1 in DRAIN -> RUN, and the period is not interrupted.
- PWM[n] = (state != STOP) & (CNTR < active duty[n]); combinational, no added latency.
- Width rules: 4-bit unsigned compare; period = active top + 1 cycles.
  - duty 0 gives constant low.
  - duty > top gives constant high.
  - top = 15 caps duty at 15/16.
  - top = 0 gives CNT_RST permanently high and PWM = (duty > 0).
- Arbiter:
  - Only one requester valid: it is granted.
  - Both valid: the one not granted most recently wins; priority pointer updates only on a completed transfer.
  - READY is combinational from VALID and the pointer; VALID must stay stable until READY.
- Write and boundary copy on the same edge: the copy takes the old shadow value; the new value applies at the following boundary.
- Writes are accepted in every state, including STOP.

## Timing
- Reset values:
  - state STOP, CNT_RST 1, PWM 0, BOUNDARY 0, READY 0.
  - all duty registers 0; both top registers 15.
  - priority pointer = A.
- The counter has no reset of its own; CNT_RST is held 1 during Reset so the counter is 0 at the first edge after release.
- EN rises at edge k (STOP -> RUN): CNTR = 0 in cycle k+1 and PWM is valid from cycle k+1.
- Write latency:
  - shadow updates at the transfer edge.
  - active updates at the first boundary edge after it (or at the STOP -> RUN edge).
- Reset asserted mid-period: outputs go to reset values immediately (asynchronously), and pending shadow values are lost.

## Structure
- Package pwm_pkg:
  - CNT_W = 4, ADDR_W = 3, ADDR_TOP = 3'd7.
  - state enum {STOP, RUN, DRAIN}.
  - reset constants TOP_RST = 15, DUTY_RST = 0.
- Sub-module pwm_rr_arbiter: 2-requester round-robin, with grant outputs and a pointer updated on transfer. Register file, FSM and comparators stay in the top.

## Test plan
- Reset release, EN = 0 for 10 cycles -> CNT_RST = 1, PWM = 0, READY low with no VALID.
- Write top = 9 and duty0 = 3 via A in STOP, then EN = 1 -> period 10 cycles, PWM[0] high for CNTR 0..2, BOUNDARY at CNTR = 9.
- While running with duty0 = 3, write duty0 = 7 mid-period -> current period still 3 high; next period 7 high; a write landing on the boundary edge applies one period later.
- VALID_A and VALID_B held together for 4 transfers -> grants alternate A, B, A, B; a lone VALID_B is granted immediately.
- EN dropped at CNTR = 4 with top = 9 -> DRAIN, period completes, STOP after CNTR = 9, PWM 0 afterwards; EN re-raised at CNTR = 6 instead -> continuous RUN.
- Edge cases:
  - duty 0 gives constant low; duty 12 with top 9 gives constant high.
  - top 0 with duty 1 gives constant high, CNT_RST = 1.
  - Reset pulse mid-period gives immediate reset values.
